// File: rtl/reloj_display_pkg.sv
// Shared constants, FSM encoding and helpers for the stopwatch display path.
package reloj_display_pkg;

  localparam int DIGITS    = 4;
  localparam int BCD_CLAMP = 99;

  // Segment patterns {g,f,e,d,c,b,a}, active-low (common anode)
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV_HI = 2'd1,
    ST_CONV_LO = 2'd2,
    ST_LOAD    = 2'd3
  } state_e;

  // Non-decimal nibbles cannot occur after clamping; they show blank
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

  // Two BCD digits only: anything above 99 saturates
  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'(BCD_CLAMP)) ? 7'(BCD_CLAMP) : v;
  endfunction

endpackage

// File: rtl/reloj_display_bcd7_serial.sv
// Serial double-dabble: 7-bit binary to two BCD digits in 7 shift cycles.
module bcd7_serial
  import reloj_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [7:0] bcd
);

  logic [6:0] bin_q;
  logic [7:0] bcd_q;
  logic [2:0] cnt_q;
  logic [7:0] adj_w;

  // Add-3 correction on each nibble ahead of the shift
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
      assign adj_w[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                            : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // Load on start, then shift the {bcd, bin} pair left once per cycle until 7 shifts are done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= 3'd7;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= 3'd0;
    end else if (cnt_q != 3'd7) begin
      bcd_q <= {adj_w[6:0], bin_q[6]};
      bin_q <= {bin_q[5:0], 1'b0};
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign done = (cnt_q == 3'd7);
  assign bcd  = bcd_q;

endmodule

// File: rtl/reloj_display.sv
// Frame-synchronous snapshot of the time bus, BCD conversion and 4-digit 7-segment scan.
module reloj_display
  import reloj_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic [6:0] hs,
  input  logic       mode,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] scan_cnt_q;
  logic [1:0]    dig_idx_q;
  logic          scan_wrap;
  logic          capture;

  state_e        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [6:0]    lo_q, lo_d;
  logic [7:0]    hi_bcd_q, hi_bcd_d;
  logic [15:0]   disp_q, disp_d;

  logic          conv_start;
  logic [6:0]    conv_bin;
  logic          conv_done;
  logic [7:0]    conv_bcd;

  logic [3:0]    digit_w [DIGITS];
  logic [3:0]    an_w;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [3:0]    an_q;

  assign scan_wrap = (scan_cnt_q == CW'(SCAN_DIV - 1));
  assign capture   = scan_wrap && (dig_idx_q == 2'd3) && (state_q == ST_IDLE);

  // Per-digit time slice and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= 2'd0;
    end else if (scan_wrap) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= dig_idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + CW'(1);
    end
  end

  // FSM next state: hi converts during steps 0..7, lo during 8..14, LOAD at step 15
  always_comb begin
    state_d    = state_q;
    step_d     = step_q + 4'd1;
    lo_d       = lo_q;
    hi_bcd_d   = hi_bcd_q;
    disp_d     = disp_q;
    conv_start = 1'b0;
    conv_bin   = lo_q;
    case (state_q)
      ST_IDLE: begin
        step_d = 4'd0;
        if (capture) begin
          conv_start = 1'b1;
          conv_bin   = clamp99(mode ? hs : min);
          lo_d       = clamp99(mode ? min : sec);
          state_d    = ST_CONV_HI;
        end
      end
      ST_CONV_HI: begin
        if (step_q == 4'd7) begin
          hi_bcd_d   = conv_bcd;
          conv_start = 1'b1;
          conv_bin   = lo_q;
          state_d    = ST_CONV_LO;
        end
      end
      ST_CONV_LO: begin
        if (step_q == 4'd14) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (conv_done) disp_d = {hi_bcd_q, conv_bcd};
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and display register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      step_q   <= 4'd0;
      lo_q     <= '0;
      hi_bcd_q <= '0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      lo_q     <= lo_d;
      hi_bcd_q <= hi_bcd_d;
      disp_q   <= disp_d;
    end
  end

  bcd7_serial u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign digit_w[gi] = disp_q[gi*4 +: 4];
      assign an_w[gi]    = (dig_idx_q != 2'(gi));
    end
  endgenerate

  // Registered pin drivers; blanking forces everything dark without touching the scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else if (blank) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_w;
      seg_q <= seg_encode(digit_w[dig_idx_q]);
      dp_q  <= (dig_idx_q != 2'd2);
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reloj_display.sv
// Directed bench for reloj_display with a short scan period.
module tb_reloj_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] sec, min, hs;
  logic       mode, blank;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  reloj_display #(.SCAN_DIV(8)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .sec   (sec),
    .min   (min),
    .hs    (hs),
    .mode  (mode),
    .blank (blank),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic level, input string tag);
    int t;
    t = 0;
    while (busy !== level && t < 100) begin
      tick();
      t++;
    end
    chk(tag, 16'(busy), 16'(level));
  endtask

  // Walks digit positions 2,3,0,1 so all four are seen before the next frame's LOAD
  task automatic show(input int d3, input int d2, input int d1, input int d0, input string tag);
    int dg [4];
    int ord [4];
    int p;
    int t;
    logic [3:0] want;
    dg  = '{d0, d1, d2, d3};
    ord = '{2, 3, 0, 1};
    for (int k = 0; k < 4; k++) begin
      p    = ord[k];
      want = ~(4'b0001 << p);
      t    = 0;
      while (an !== want && t < 60) begin
        tick();
        t++;
      end
      chk({tag, " an"}, 16'(an), 16'(want));
      chk({tag, " seg"}, 16'(seg), 16'(segtab[dg[p]]));
      chk({tag, " dp"}, 16'(dp), (p == 2) ? 16'd0 : 16'd1);
    end
  endtask

  initial begin
    int n;
    logic [6:0] sv [4];
    int e1 [4];
    int e0 [4];

    // Test 1: reset values, then a reset asserted mid-scan
    rst_n = 1'b0; mode = 1'b0; blank = 1'b0; hs = 7'd0; min = 7'd12; sec = 7'd34;
    repeat (3) tick();
    chk("rst an", 16'(an), 16'hF);
    chk("rst seg", 16'(seg), 16'h7F);
    chk("rst dp", 16'(dp), 16'd1);
    chk("rst busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    repeat (13) tick();
    chk("scan an", 16'(an), 16'(4'b1101));
    chk("scan seg zero", 16'(seg), 16'(segtab[0]));
    rst_n = 1'b0;
    #1;
    chk("midrst an", 16'(an), 16'hF);
    chk("midrst seg", 16'(seg), 16'h7F);
    chk("midrst dp", 16'(dp), 16'd1);
    chk("midrst busy", 16'(busy), 16'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Test 2: display reads 0000 until the first LOAD, then 12.34
    show(0, 0, 0, 0, "init");
    wait_busy(1'b1, "t2 rise");
    wait_busy(1'b0, "t2 fall");
    show(1, 2, 3, 4, "t2");

    // Test 3: hs.min mode, busy length from capture
    wait_busy(1'b0, "t3 idle");
    mode = 1'b1; hs = 7'd7; min = 7'd5;
    wait_busy(1'b1, "t3 rise");
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("busy len", 16'(n), 16'd16);
    show(0, 7, 0, 5, "t3");

    // Test 4: clamp on the lo value
    sv = '{7'd127, 7'd100, 7'd99, 7'd0};
    e1 = '{9, 9, 9, 0};
    e0 = '{9, 9, 9, 0};
    for (int i = 0; i < 4; i++) begin
      wait_busy(1'b0, "t4 idle");
      mode = 1'b0; min = 7'd12; sec = sv[i];
      wait_busy(1'b1, "t4 rise");
      wait_busy(1'b0, "t4 fall");
      show(1, 2, e1[i], e0[i], "t4 clamp");
    end

    // Test 5: input change while busy is ignored until the next frame
    wait_busy(1'b0, "t5 idle");
    sec = 7'd34;
    wait_busy(1'b1, "t5 rise");
    sec = 7'd56;
    wait_busy(1'b0, "t5 fall");
    show(1, 2, 3, 4, "t5 hold");
    wait_busy(1'b1, "t5 rise2");
    wait_busy(1'b0, "t5 fall2");
    show(1, 2, 5, 6, "t5 next");

    // Test 6: blanking keeps conversion running
    wait_busy(1'b1, "t6 rise");
    wait_busy(1'b0, "t6 fall");
    sec = 7'd7;
    blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("blank an", 16'(an), 16'hF);
      chk("blank seg", 16'(seg), 16'h7F);
    end
    blank = 1'b0;
    wait_busy(1'b1, "t6 conv");
    wait_busy(1'b0, "t6 done");
    show(1, 2, 0, 7, "t6");

    // Test 7: reset during CONV_LO aborts and clears the display
    wait_busy(1'b0, "t7 idle");
    wait_busy(1'b1, "t7 rise");
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("t7 busy", 16'(busy), 16'd0);
    chk("t7 an", 16'(an), 16'hF);
    chk("t7 seg", 16'(seg), 16'h7F);
    repeat (2) tick();
    rst_n = 1'b1;
    show(0, 0, 0, 0, "t7 clear");
    wait_busy(1'b1, "t7 rise2");
    wait_busy(1'b0, "t7 fall2");
    show(1, 2, 0, 7, "t7 after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
